lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
Load/store unit for the MEM stage of the 5-stage RISC-V core. It sits between the EX/MEM pipeline register and the word-addressed data memory, which has a combinational read and a full-word write on the clock edge.
- Converts byte addresses to word indices.
- Performs read-modify-write for SB/SH stores.
- Extracts and sign- or zero-extends LB/LH/LBU/LHU/LW results.
- Flags misaligned or out-of-range accesses.
- Two registered stages with valid/ready handshakes on both sides.

Parameters:
MEM_DEPTH, 10, log2 of data-memory word count; valid byte addresses are 0 .. (4<<MEM_DEPTH)-1

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request present from EX/MEM
req_ready  output  1  request accepted this cycle when req_valid&&req_ready
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  zero-extend load result (LBU/LHU)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response held in S2
resp_ready  input  1  writeback consumes response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, illegal size or out-of-range
mem_wr  output  1  memory write strobe
mem_addr  output  32  word index, zero-extended
mem_wdata  output  32  full word to write
mem_rdata  input  32  combinational memory read of mem_addr

Behaviour:
- S1 register: s1_valid plus captured we, size, unsigned, addr and wdata. Loads on request acceptance.
- S2 register: resp_valid, resp_rdata, resp_err.
- s1_adv = s1_valid && (!resp_valid || resp_ready).
- req_ready = !s1_valid || s1_adv. This is combinational from resp_ready.
- mem_addr = {zeros, s1_addr[MEM_DEPTH+1:2]}. It is driven whenever s1_valid and is 0 otherwise.
- Error conditions, evaluated on S1 contents:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:MEM_DEPTH+2] != 0.
- mem_wr = s1_adv && s1_we && !err. Exactly one write per store, only in its advance cycle; a stalled store never writes early.
- Store merge uses mem_rdata in the same cycle as the write:
  - byte: replace lane addr[1:0] with wdata[7:0];
  - half: replace lane addr[1] with wdata[15:0];
  - word: write wdata directly.
- Load extraction: select the lane as for stores, then sign-extend unless unsigned. Word loads ignore the unsigned flag.
- On s1_adv, S2 captures:
  - rdata = load ? extracted value : 0;
  - err = err;
  - resp_valid = 1.
- If s1_adv is false and resp_valid && resp_ready, resp_valid clears.
- Latency: accept at edge N gives resp_valid after edge N+1. Throughput is 1 per cycle when resp_ready stays high.
- Back-pressure: while resp_valid && !resp_ready, S2 holds its contents, S1 holds its contents, and req_ready = !s1_valid.
- Store then load to the same word, back to back: the load reads the updated data, because the write commits at the edge before the load occupies S1.
- Reset values: s1_valid=0, resp_valid=0, resp_rdata=0, resp_err=0, hence mem_wr=0, mem_addr=0 and req_ready=1.
- Reset mid-operation: in-flight requests are dropped and no write is issued.

Optional Feature:
Macro LSU_STATS_EN.
- Defined:
  - Adds 32-bit outputs stat_loads, stat_stores and stat_errs, all reset to 0.
  - Each increments by 1 on s1_adv for a good load, a good store, or any error respectively.
  - Counters wrap at 2^32.
- Undefined: these ports and their logic are absent. Datapath behaviour is identical in both builds.

Decomposition:
- Package lsu_pkg:
  - SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_ILL=2'b11;
  - a function or constant for the address-range check width.
- Sub-module lsu_align, purely combinational:
  - inputs: size, addr[1:0], unsigned, wdata, rdata;
  - outputs: merged store word, extended load data, misalign flag.
- lsu_mem_stage holds both pipeline registers, the handshake logic and the optional counters.

Test Plan:
- SW addr 0x10 data 0xAABBCCDD, then LW 0x10 -> mem_addr=4, one mem_wr pulse, load resp_rdata=0xAABBCCDD, resp_err=0.
- Word 0x10 preloaded 0x11223344, SB addr 0x13 data 0xFF -> written word 0xFF223344; LB 0x13 -> 0xFFFFFFFF; LBU 0x13 -> 0x000000FF.
- SH addr 0x12 data 0x8001, then LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001; low half 0x3344 is unchanged.
- LW 0x11, SH 0x13 and an access at 0x1000 with MEM_DEPTH=10 -> resp_err=1, resp_rdata=0, mem_wr never asserted.
- Hold resp_ready=0 for 3 cycles with SW pending in S1 -> req_ready=0, no mem_wr until release; then a single write and in-order responses; back-to-back loads with resp_ready=1 give one resp per cycle.
- Assert rst_n low while a store is in S1 and the response is stalled -> resp_valid=0, no write, memory unchanged; with LSU_STATS_EN, counters read 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and helpers for the MEM-stage load/store unit.
// Access-size encoding matches the req_size field coming from EX/MEM.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    // Lowest byte-address bit that must be zero for an in-range access:
    // MEM_DEPTH word-index bits sit above the two byte-lane bits.
    function automatic int unsigned range_lsb(input int unsigned mem_depth);
        return mem_depth + 2;
    endfunction

    // True when any address bit above the data memory's span is set.
    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input int unsigned mem_depth);
        return (addr >> range_lsb(mem_depth)) != 32'd0;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational byte-lane steering for the load/store unit.
// Builds the full store word (read-modify-write merge for SB/SH), extracts and
// extends load data, and flags misaligned or illegal-size accesses.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_store_word,
    output logic [31:0] o_load_data,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and half-word lanes of the current memory word
    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Merge store data into the current word; word stores replace it outright
    always_comb begin
        o_store_word = i_rdata;
        case (size_e'(i_size))
            SZ_BYTE: o_store_word[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
            SZ_HALF: o_store_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            SZ_WORD: o_store_word = i_wdata;
            SZ_ILL:  o_store_word = i_rdata;
            default: o_store_word = i_rdata;
        endcase
    end

    // Extend the selected lane; word loads ignore the unsigned flag
    always_comb begin
        o_load_data = i_rdata;
        case (size_e'(i_size))
            SZ_BYTE: o_load_data = i_unsigned ? {24'd0, w_byte}
                                              : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = i_unsigned ? {16'd0, w_half}
                                              : {{16{w_half[15]}}, w_half};
            SZ_WORD: o_load_data = i_rdata;
            SZ_ILL:  o_load_data = i_rdata;
            default: o_load_data = i_rdata;
        endcase
    end

    // Alignment check; the illegal size encoding is reported here as well
    always_comb begin
        o_misalign = 1'b0;
        case (size_e'(i_size))
            SZ_BYTE: o_misalign = 1'b0;
            SZ_HALF: o_misalign = i_addr_lo[0];
            SZ_WORD: o_misalign = (i_addr_lo != 2'b00);
            SZ_ILL:  o_misalign = 1'b1;
            default: o_misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit of the 5-stage RISC-V core.
// S1 holds the accepted request and drives the word-addressed data memory
// (combinational read, write on the clock edge); S2 holds the response.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid may not depend on ready, and a held response never changes.
// Optional build macro LSU_STATS_EN adds load/store/error event counters.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int MEM_DEPTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
`ifdef LSU_STATS_EN
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_errs,
`endif
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // S1: accepted request waiting for its memory access
    logic        r_s1_valid;
    logic        r_s1_we;
    logic [1:0]  r_s1_size;
    logic        r_s1_unsigned;
    logic [31:0] r_s1_addr;
    logic [31:0] r_s1_wdata;

    // S2: response presented to writeback
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_s1_adv;
    logic        w_accept;
    logic        w_misalign;
    logic        w_range_err;
    logic        w_err;
    logic [31:0] w_store_word;
    logic [31:0] w_load_data;

    lsu_align u_align (
        .i_size       (r_s1_size),
        .i_addr_lo    (r_s1_addr[1:0]),
        .i_unsigned   (r_s1_unsigned),
        .i_wdata      (r_s1_wdata),
        .i_rdata      (mem_rdata),
        .o_store_word (w_store_word),
        .o_load_data  (w_load_data),
        .o_misalign   (w_misalign)
    );

    // S1 moves to S2 whenever S2 is empty or being drained this cycle
    assign w_s1_adv    = r_s1_valid && (!r_resp_valid || resp_ready);
    assign req_ready   = !r_s1_valid || w_s1_adv;
    assign w_accept    = req_valid && req_ready;

    assign w_range_err = addr_out_of_range(r_s1_addr, MEM_DEPTH);
    assign w_err       = w_misalign || w_range_err;

    // Memory is only addressed while S1 is occupied. The store writes only in
    // its advance cycle so a stalled store cannot commit early or twice.
    assign mem_addr    = r_s1_valid ? 32'(r_s1_addr[MEM_DEPTH+1:2]) : 32'd0;
    assign mem_wdata   = w_store_word;
    assign mem_wr      = w_s1_adv && r_s1_we && !w_err;

    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;

    // S1 register: capture on acceptance, empty when it advances without refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_we       <= 1'b0;
            r_s1_size     <= 2'b00;
            r_s1_unsigned <= 1'b0;
            r_s1_addr     <= 32'd0;
            r_s1_wdata    <= 32'd0;
        end else if (w_accept) begin
            r_s1_valid    <= 1'b1;
            r_s1_we       <= req_we;
            r_s1_size     <= req_size;
            r_s1_unsigned <= req_unsigned;
            r_s1_addr     <= req_addr;
            r_s1_wdata    <= req_wdata;
        end else if (w_s1_adv) begin
            r_s1_valid    <= 1'b0;
        end
    end

    // S2 register: load data or zero for stores/errors; clears once consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else if (w_s1_adv) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= (r_s1_we || w_err) ? 32'd0 : w_load_data;
            r_resp_err   <= w_err;
        end else if (r_resp_valid && resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

`ifdef LSU_STATS_EN
    logic [31:0] r_stat_loads;
    logic [31:0] r_stat_stores;
    logic [31:0] r_stat_errs;

    // Event counters, one bump per completed access; they wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_loads  <= 32'd0;
            r_stat_stores <= 32'd0;
            r_stat_errs   <= 32'd0;
        end else if (w_s1_adv) begin
            if (w_err)
                r_stat_errs   <= r_stat_errs + 32'd1;
            else if (r_s1_we)
                r_stat_stores <= r_stat_stores + 32'd1;
            else
                r_stat_loads  <= r_stat_loads + 32'd1;
        end
    end

    assign stat_loads  = r_stat_loads;
    assign stat_stores = r_stat_stores;
    assign stat_errs   = r_stat_errs;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed bench for lsu_mem_stage with MEM_DEPTH=10.
// Provides a word-addressed memory model, drives requests after each rising
// edge and samples outputs on falling edges. Responses are checked in order
// against an expected queue of {err, rdata} values worked out by hand.
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef LSU_STATS_EN
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_errs;
`endif

    lsu_mem_stage #(.MEM_DEPTH(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
`ifdef LSU_STATS_EN
        .stat_loads   (stat_loads),
        .stat_stores  (stat_stores),
        .stat_errs    (stat_errs),
`endif
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    logic [31:0] mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (mem_wr)
            mem[mem_addr[9:0]] <= mem_wdata;
        else if (pl_en)
            mem[pl_idx] <= pl_data;
    end
    assign mem_rdata = mem[mem_addr[9:0]];

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    int          pop_cyc[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          wr_cnt = 0;
    int          n_stall = 0;
    logic [31:0] last_wr_addr = 32'd0;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Response and write monitor; each sampled handshake completes on the next rising edge
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0)
                chk("resp_unexpected", {resp_err, resp_rdata}, 33'h1_DEAD_DEAD);
            else
                chk("resp", {resp_err, resp_rdata}, exp_q.pop_front());
        end
        if (rst_n && mem_wr) begin
            wr_cnt++;
            last_wr_addr = mem_addr;
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd);
        logic accepted;
        accepted     = 1'b0;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                accepted = 1'b1;
                break;
            end
            n_stall++;
        end
        if (!accepted) chk("req_accept", 33'(accepted), 33'd1);
        @(posedge clk);
        #1;
        exp_q.push_back({exp_err, exp_rd});
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        chk("drain_left", 33'(exp_q.size()), 33'd0);
        #1;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = data;
        @(posedge clk);
        #1;
        pl_en   = 1'b0;
    endtask

    // ---------------- directed test ----------------
    int wr_base;

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        resp_ready   = 1'b1;
        pl_en        = 1'b0;
        pl_idx       = 10'd0;
        pl_data      = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready",  33'(req_ready),  33'd1);
        chk("rst_resp_valid", 33'(resp_valid), 33'd0);
        chk("rst_resp_rdata", 33'(resp_rdata), 33'd0);
        chk("rst_resp_err",   33'(resp_err),   33'd0);
        chk("rst_mem_wr",     33'(mem_wr),     33'd0);
        chk("rst_mem_addr",   33'(mem_addr),   33'd0);
`ifdef LSU_STATS_EN
        chk("rst_stat_loads", 33'(stat_loads), 33'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        preload(10'd1023, 32'h80A1_B2C3);

        // SW then LW to the same word back to back
        wr_base = wr_cnt;
        send(1'b1, 2'b10, 1'b0, 32'h10, 32'hAABB_CCDD, 1'b0, 32'h0);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b0, 32'hAABB_CCDD);
        drain();
        chk("sw_wr_count", 33'(wr_cnt - wr_base), 33'd1);
        chk("sw_wr_addr",  33'(last_wr_addr),     33'd4);
        chk("sw_mem4",     33'(mem[4]),           33'hAABB_CCDD);

        // SB into a preloaded word, then signed and unsigned byte loads
        preload(10'd4, 32'h1122_3344);
        send(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00FF, 1'b0, 32'h0);
        send(1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         1'b0, 32'hFFFF_FFFF);
        send(1'b0, 2'b00, 1'b1, 32'h13, 32'h0,         1'b0, 32'h0000_00FF);
        drain();
        chk("sb_mem4", 33'(mem[4]), 33'hFF22_3344);

        // SH to the upper half, then signed and unsigned half loads
        send(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001, 1'b0, 32'h0);
        send(1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         1'b0, 32'hFFFF_8001);
        send(1'b0, 2'b01, 1'b1, 32'h12, 32'h0,         1'b0, 32'h0000_8001);
        drain();
        chk("sh_mem4", 33'(mem[4]), 33'h8001_3344);

        // Error cases and the highest valid byte address
        wr_base = wr_cnt;
        send(1'b0, 2'b10, 1'b0, 32'h11,   32'h0,         1'b1, 32'h0);
        send(1'b1, 2'b01, 1'b0, 32'h13,   32'h0000_5555, 1'b1, 32'h0);
        send(1'b1, 2'b10, 1'b0, 32'h1000, 32'h1234_5678, 1'b1, 32'h0);
        send(1'b0, 2'b11, 1'b0, 32'h10,   32'h0,         1'b1, 32'h0);
        send(1'b0, 2'b00, 1'b0, 32'hFFF,  32'h0,         1'b0, 32'hFFFF_FF80);
        drain();
        chk("err_no_write", 33'(wr_cnt - wr_base), 33'd0);
        chk("err_mem4",     33'(mem[4]),           33'h8001_3344);

        // Back-pressure: SW stuck in S1 behind an unconsumed LW
        wr_base    = wr_cnt;
        resp_ready = 1'b0;
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b0, 32'h8001_3344);
        send(1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_req_ready",  33'(req_ready),  33'd0);
            chk("bp_mem_wr",     33'(mem_wr),     33'd0);
            chk("bp_resp_valid", 33'(resp_valid), 33'd1);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        drain();
        chk("bp_wr_count", 33'(wr_cnt - wr_base), 33'd1);
        chk("bp_wr_addr",  33'(last_wr_addr),     33'd8);
        chk("bp_mem8",     33'(mem[8]),           33'h1234_5678);

        // Back-to-back loads: one accept and one response per cycle
        n_stall = 0;
        pop_cyc.delete();
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h8001_3344);
        send(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1234_5678);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h8001_3344);
        send(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1234_5678);
        drain();
        chk("burst_stalls", 33'(n_stall),        33'd0);
        chk("burst_pops",   33'(pop_cyc.size()), 33'd4);
        if (pop_cyc.size() == 4)
            chk("burst_span", 33'(pop_cyc[3] - pop_cyc[0]), 33'd3);

`ifdef LSU_STATS_EN
        chk("stat_loads",  33'(stat_loads),  33'd11);
        chk("stat_stores", 33'(stat_stores), 33'd4);
        chk("stat_errs",   33'(stat_errs),   33'd4);
`endif

        // Reset while a store sits in S1 behind a stalled response
        wr_base    = wr_cnt;
        resp_ready = 1'b0;
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b0, 32'h8001_3344);
        send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
        @(negedge clk);
        chk("pre_rst_req_ready", 33'(req_ready), 33'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", 33'(resp_valid), 33'd0);
        chk("mid_rst_req_ready",  33'(req_ready),  33'd1);
        chk("mid_rst_mem_wr",     33'(mem_wr),     33'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_wr_count",  33'(wr_cnt - wr_base), 33'd0);
        chk("post_rst_mem4",      33'(mem[4]),           33'h8001_3344);
        chk("post_rst_resp_valid", 33'(resp_valid),      33'd0);
`ifdef LSU_STATS_EN
        chk("post_rst_stat_loads",  33'(stat_loads),  33'd0);
        chk("post_rst_stat_stores", 33'(stat_stores), 33'd0);
        chk("post_rst_stat_errs",   33'(stat_errs),   33'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
